// File: rtl/fir_sched_pkg.sv
// Shared types and constants for the FIR core scheduler.
package fir_sched_pkg;

  // Tap count of the FIR core; one reload always carries this many coefficients.
  localparam int NUM_COEF_DEFAULT = 4;

  // Index width for the default tap count.
  localparam int COEF_IDX_W = $clog2(NUM_COEF_DEFAULT);

  // Index width for an arbitrary tap count (never narrower than one bit).
  function automatic int coef_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Scheduler states: one reload path (C_*) and one sample path (S_*).
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_C_ISSUE  = 3'd1,
    ST_C_ARM    = 3'd2,
    ST_C_WAIT   = 3'd3,
    ST_S_ISSUE1 = 3'd4,
    ST_S_ISSUE2 = 3'd5,
    ST_S_ARM    = 3'd6,
    ST_S_WAIT   = 3'd7
  } sched_state_e;

endpackage

// File: rtl/fir_core_scheduler_if.sv
// Single-issue dr/lc handshake between the scheduler (master) and the FIR core (slave).
interface fir_core_if #(
  parameter int DATA_W = 16
);
  logic              dr;
  logic              lc;
  logic [DATA_W-1:0] fir_in;
  logic              modwait;
  logic              core_err;
  logic [DATA_W-1:0] core_out;

  modport master (
    output dr,
    output lc,
    output fir_in,
    input  modwait,
    input  core_err,
    input  core_out
  );

  modport slave (
    input  dr,
    input  lc,
    input  fir_in,
    output modwait,
    output core_err,
    output core_out
  );
endinterface

// File: rtl/fir_core_scheduler_timeout_counter.sv
// Clear/enable cycle counter that flags (and wraps) on its LIMIT-th enabled cycle.
module sched_timeout_counter #(
  parameter int LIMIT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic rollover
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_q, count_d;

  assign rollover = en && (count_q == CW'(LIMIT - 1));

  // Clear has priority; otherwise count while enabled and wrap at the limit.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = rollover ? '0 : count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/fir_core_scheduler.sv
// FIR core scheduler: serialises sample and coefficient-reload requests onto the
// core's dr/lc interface and enforces the modwait handshake.
// Optional watchdog: define FIR_SCHED_TIMEOUT_EN to abort ARM/WAIT states after
// TIMEOUT_CYCLES cycles (sets err_flag, restarts an interrupted reload from F0).
module fir_core_scheduler
  import fir_sched_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int NUM_COEF       = NUM_COEF_DEFAULT,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_valid,
  input  logic [DATA_W-1:0]          sample_data,
  output logic                       sample_accept,
  input  logic                       new_coef_set,
  input  logic [NUM_COEF*DATA_W-1:0] fir_coef,
  output logic                       coef_busy,
  output logic                       coef_done,
  fir_core_if.master                 core,
  output logic                       result_valid,
  output logic [DATA_W-1:0]          result_data,
  output logic                       err_flag
);
  localparam int IDX_W = (NUM_COEF == NUM_COEF_DEFAULT) ? COEF_IDX_W : coef_idx_width(NUM_COEF);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEF - 1);

  sched_state_e      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] fir_in_q, fir_in_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              sample_accept_q, sample_accept_d;
  logic              coef_done_q, coef_done_d;
  logic              result_valid_q, result_valid_d;
  logic              err_q, err_d;
  logic              coef_req;
  logic              timeout_hit;

  logic [DATA_W-1:0] coef_word [NUM_COEF];

  for (genvar gi = 0; gi < NUM_COEF; gi++) begin : g_coef_word
    assign coef_word[gi] = fir_coef[gi*DATA_W +: DATA_W];
  end

  // A set that has just completed is not restarted while the slave is still
  // reacting to coef_done; this also guarantees an IDLE gap after a reload.
  assign coef_req = new_coef_set && !coef_done_q;

`ifdef FIR_SCHED_TIMEOUT_EN
  logic in_wait;

  assign in_wait = (state_q == ST_C_ARM) || (state_q == ST_C_WAIT) ||
                   (state_q == ST_S_ARM) || (state_q == ST_S_WAIT);

  sched_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr      (!in_wait),
    .en       (in_wait),
    .rollover (timeout_hit)
  );
`else
  // Watchdog compiled out: ARM/WAIT states wait for modwait indefinitely.
  assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  // Next-state, index, bus and pulse computation.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    fir_in_d        = fir_in_q;
    result_d        = result_q;
    err_d           = err_q;
    sample_accept_d = 1'b0;
    coef_done_d     = 1'b0;
    result_valid_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (coef_req) begin
          state_d = ST_C_ISSUE;
        end else if (sample_valid) begin
          state_d         = ST_S_ISSUE1;
          sample_accept_d = 1'b1;
          fir_in_d        = sample_data;
        end
      end
      ST_C_ISSUE: state_d = ST_C_ARM;
      ST_C_ARM: begin
        if (core.modwait) state_d = ST_C_WAIT;
      end
      ST_C_WAIT: begin
        if (!core.modwait) begin
          if (idx_q == LAST_IDX) begin
            idx_d       = '0;
            coef_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_C_ISSUE;
          end
        end
      end
      ST_S_ISSUE1: state_d = ST_S_ISSUE2;
      ST_S_ISSUE2: state_d = ST_S_ARM;
      ST_S_ARM: begin
        if (core.modwait) state_d = ST_S_WAIT;
      end
      ST_S_WAIT: begin
        if (!core.modwait) begin
          result_d       = core.core_out;
          result_valid_d = 1'b1;
          err_d          = core.core_err;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Watchdog abort: drop the operation, flag the error, rewind the reload.
    if (timeout_hit) begin
      state_d        = ST_IDLE;
      idx_d          = '0;
      err_d          = 1'b1;
      coef_done_d    = 1'b0;
      result_valid_d = 1'b0;
      result_d       = result_q;
    end

    // Present the coefficient on the bus for the lc cycle.
    if (state_d == ST_C_ISSUE) begin
      fir_in_d = coef_word[idx_d];
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      idx_q           <= '0;
      fir_in_q        <= '0;
      result_q        <= '0;
      err_q           <= 1'b0;
      sample_accept_q <= 1'b0;
      coef_done_q     <= 1'b0;
      result_valid_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      fir_in_q        <= fir_in_d;
      result_q        <= result_d;
      err_q           <= err_d;
      sample_accept_q <= sample_accept_d;
      coef_done_q     <= coef_done_d;
      result_valid_q  <= result_valid_d;
    end
  end

  assign core.dr     = (state_q == ST_S_ISSUE1) || (state_q == ST_S_ISSUE2);
  assign core.lc     = (state_q == ST_C_ISSUE);
  assign core.fir_in = fir_in_q;
  assign coef_busy   = (state_q == ST_C_ISSUE) || (state_q == ST_C_ARM) || (state_q == ST_C_WAIT);
  assign coef_done     = coef_done_q;
  assign sample_accept = sample_accept_q;
  assign result_valid  = result_valid_q;
  assign result_data   = result_q;
  assign err_flag      = err_q;

endmodule

// File: tb/tb_fir_core_scheduler.sv
// Directed self-checking bench for fir_core_scheduler with a small FIR core model.
module tb_fir_core_scheduler;
  localparam int DW = 16;
  localparam int NC = 4;

  logic             clk;
  logic             rst;
  logic             sample_valid;
  logic [DW-1:0]    sample_data;
  logic             sample_accept;
  logic             new_coef_set;
  logic [NC*DW-1:0] fir_coef;
  logic             coef_busy;
  logic             coef_done;
  logic             result_valid;
  logic [DW-1:0]    result_data;
  logic             err_flag;

  fir_core_if #(.DATA_W(DW)) cif ();

  fir_core_scheduler #(
    .DATA_W         (DW),
    .NUM_COEF       (NC),
    .TIMEOUT_CYCLES (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_valid  (sample_valid),
    .sample_data   (sample_data),
    .sample_accept (sample_accept),
    .new_coef_set  (new_coef_set),
    .fir_coef      (fir_coef),
    .coef_busy     (coef_busy),
    .coef_done     (coef_done),
    .core          (cif),
    .result_valid  (result_valid),
    .result_data   (result_data),
    .err_flag      (err_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Core model: modwait rises the cycle after lc, or the cycle after dr falls,
  // and stays high for the configured number of cycles (or forever if stuck).
  int   coef_busy_len;
  int   samp_busy_len;
  logic stuck_mw;
  int   mw_cnt;
  logic dr_prev;

  always @(posedge clk) begin
    dr_prev <= cif.dr;
    if (stuck_mw) begin
      cif.modwait <= 1'b1;
    end else if (cif.lc) begin
      mw_cnt      <= coef_busy_len - 1;
      cif.modwait <= 1'b1;
    end else if (dr_prev && !cif.dr) begin
      mw_cnt      <= samp_busy_len - 1;
      cif.modwait <= 1'b1;
    end else if (mw_cnt > 0) begin
      mw_cnt      <= mw_cnt - 1;
      cif.modwait <= 1'b1;
    end else begin
      cif.modwait <= 1'b0;
    end
  end

  int total;
  int bad;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Transaction trackers, filled in at every negedge by step().
  int          cyc;
  int          lc_cnt, lc_double;
  logic        lc_prev;
  logic [31:0] lc_vals[$];
  int          dr_cnt, dr_first_cyc, dr_last_cyc;
  logic [31:0] dr_vals[$];
  int          done_cnt, done_cyc;
  logic        busy_at_done;
  int          acc_cnt, acc_cyc;
  int          rv_cnt, rv_cyc;
  logic [31:0] rv_data;

  function automatic logic [31:0] lc_at(input int i);
    return (i < lc_vals.size()) ? lc_vals[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] dr_at(input int i);
    return (i < dr_vals.size()) ? dr_vals[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic clear_trk();
    lc_cnt = 0; lc_double = 0; lc_prev = 1'b0; lc_vals.delete();
    dr_cnt = 0; dr_first_cyc = -1; dr_last_cyc = -1; dr_vals.delete();
    done_cnt = 0; done_cyc = -1; busy_at_done = 1'b1;
    acc_cnt = 0; acc_cyc = -1;
    rv_cnt = 0; rv_cyc = -1; rv_data = 32'hDEAD_BEEF;
  endtask

  // Advance one cycle, record observed events, and act as the slave register
  // block (drop requests once they are acknowledged).
  task automatic step();
    @(negedge clk);
    cyc++;
    if (cif.lc) begin
      lc_cnt++;
      lc_vals.push_back(32'(cif.fir_in));
      if (lc_prev) lc_double++;
    end
    lc_prev = cif.lc;
    if (cif.dr) begin
      dr_cnt++;
      dr_vals.push_back(32'(cif.fir_in));
      if (dr_first_cyc < 0) dr_first_cyc = cyc;
      dr_last_cyc = cyc;
    end
    if (coef_done) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = coef_busy;
      new_coef_set = 1'b0;
    end
    if (sample_accept) begin
      acc_cnt++;
      acc_cyc      = cyc;
      sample_valid = 1'b0;
    end
    if (result_valid) begin
      rv_cnt++;
      rv_cyc  = cyc;
      rv_data = 32'(result_data);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [31:0] out_bits();
    return 32'({cif.dr, cif.lc, coef_busy, coef_done, sample_accept, result_valid, err_flag});
  endfunction

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst = 1'b1; sample_valid = 1'b0; sample_data = '0;
    new_coef_set = 1'b0; fir_coef = '0;
    cif.core_err = 1'b0; cif.core_out = '0;
    coef_busy_len = 1; samp_busy_len = 12; stuck_mw = 1'b0;
    clear_trk();
    run(3);

    // Reset state.
    check_val("rst_ctrl_outs", out_bits(), 32'h0);
    check_val("rst_fir_in", 32'(cif.fir_in), 32'h0);
    check_val("rst_result_data", 32'(result_data), 32'h0);
    $display("txn reset: outs=0x%0h fir_in=0x%0h", out_bits(), cif.fir_in);
    rst = 1'b0;
    run(2);

    // Reload with modwait high for one cycle per coefficient.
    clear_trk();
    coef_busy_len = 1;
    fir_coef      = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    new_coef_set  = 1'b1;
    run(30);
    check_val("reload_lc_count", 32'(lc_cnt), 32'd4);
    check_val("reload_lc_single", 32'(lc_double), 32'd0);
    check_val("reload_f0", lc_at(0), 32'h0001);
    check_val("reload_f1", lc_at(1), 32'h0002);
    check_val("reload_f2", lc_at(2), 32'h0003);
    check_val("reload_f3", lc_at(3), 32'h0004);
    check_val("reload_done_count", 32'(done_cnt), 32'd1);
    check_val("reload_busy_at_done", 32'(busy_at_done), 32'd0);
    check_val("reload_no_dr", 32'(dr_cnt), 32'd0);
    $display("txn reload: lc=%0d done=%0d", lc_cnt, done_cnt);

    // Sample with a 12-cycle busy core.
    clear_trk();
    samp_busy_len = 12;
    cif.core_out  = 16'h0ABC;
    cif.core_err  = 1'b0;
    sample_data   = 16'h0100;
    sample_valid  = 1'b1;
    run(30);
    check_val("samp_accept_count", 32'(acc_cnt), 32'd1);
    check_val("samp_dr_count", 32'(dr_cnt), 32'd2);
    check_val("samp_dr_with_accept", 32'(dr_first_cyc), 32'(acc_cyc));
    check_val("samp_dr_consecutive", 32'(dr_last_cyc - dr_first_cyc), 32'd1);
    check_val("samp_dr_bus0", dr_at(0), 32'h0100);
    check_val("samp_dr_bus1", dr_at(1), 32'h0100);
    check_val("samp_rv_count", 32'(rv_cnt), 32'd1);
    check_val("samp_rv_data", rv_data, 32'h0ABC);
    check_val("samp_latency", 32'(rv_cyc - acc_cyc), 32'd16);
    check_val("samp_err_clear", 32'(err_flag), 32'd0);
    $display("txn sample: data=0x%0h latency=%0d", rv_data, rv_cyc - acc_cyc);

    // Simultaneous reload and sample: reload runs first, then the held sample.
    clear_trk();
    fir_coef      = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
    sample_data   = 16'h0555;
    cif.core_out  = 16'h0123;
    samp_busy_len = 2;
    new_coef_set  = 1'b1;
    sample_valid  = 1'b1;
    run(50);
    check_val("simul_lc_count", 32'(lc_cnt), 32'd4);
    check_val("simul_f0", lc_at(0), 32'h0011);
    check_val("simul_f3", lc_at(3), 32'h0044);
    check_val("simul_done_count", 32'(done_cnt), 32'd1);
    check_val("simul_accept_after_done", 32'(acc_cyc > done_cyc), 32'd1);
    check_val("simul_dr_bus", dr_at(0), 32'h0555);
    check_val("simul_rv_data", rv_data, 32'h0123);
    $display("txn simul: done_cyc=%0d acc_cyc=%0d", done_cyc, acc_cyc);

    // Core error sets err_flag; a reload keeps it; a clean sample clears it.
    clear_trk();
    samp_busy_len = 3;
    cif.core_err  = 1'b1;
    cif.core_out  = 16'h7FFF;
    sample_data   = 16'h0200;
    sample_valid  = 1'b1;
    run(20);
    check_val("err_set", 32'(err_flag), 32'd1);
    check_val("err_rv_data", rv_data, 32'h7FFF);
    check_val("err_latency", 32'(rv_cyc - acc_cyc), 32'd7);
    cif.core_err = 1'b0;
    clear_trk();
    fir_coef     = {16'h0008, 16'h0007, 16'h0006, 16'h0005};
    new_coef_set = 1'b1;
    run(20);
    check_val("err_reload_done", 32'(done_cnt), 32'd1);
    check_val("err_kept_by_reload", 32'(err_flag), 32'd1);
    clear_trk();
    cif.core_out = 16'h0042;
    sample_data  = 16'h0201;
    sample_valid = 1'b1;
    run(20);
    check_val("err_cleared", 32'(err_flag), 32'd0);
    check_val("err_clear_rv_data", rv_data, 32'h0042);
    $display("txn err: err_flag=%0b data=0x%0h", err_flag, rv_data);

    // Reset during C_WAIT of the second coefficient, then restart from F0.
    clear_trk();
    coef_busy_len = 3;
    fir_coef      = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
    new_coef_set  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (lc_cnt < 2) step();
    end
    check_val("rstmid_second_lc", 32'(lc_cnt), 32'd2);
    run(2);
    check_val("rstmid_busy_before", 32'(coef_busy), 32'd1);
    rst = 1'b1;
    step();
    check_val("rstmid_ctrl_outs", out_bits(), 32'h0);
    check_val("rstmid_fir_in", 32'(cif.fir_in), 32'h0);
    rst = 1'b0;
    clear_trk();
    run(40);
    check_val("rstmid_restart_count", 32'(lc_cnt), 32'd4);
    check_val("rstmid_restart_f0", lc_at(0), 32'h000A);
    check_val("rstmid_restart_f3", lc_at(3), 32'h000D);
    check_val("rstmid_done_count", 32'(done_cnt), 32'd1);
    $display("txn reset_mid_reload: lc=%0d first=0x%0h", lc_cnt, lc_at(0));

    // modwait stuck high during a sample.
    clear_trk();
    stuck_mw     = 1'b1;
    cif.core_out = 16'h0BAD;
    cif.core_err = 1'b0;
    sample_data  = 16'h0300;
    sample_valid = 1'b1;
    run(60);
    check_val("stuck_accept", 32'(acc_cnt), 32'd1);
    check_val("stuck_dr_count", 32'(dr_cnt), 32'd2);
    check_val("stuck_no_result", 32'(rv_cnt), 32'd0);
`ifdef FIR_SCHED_TIMEOUT_EN
    check_val("wdog_err_set", 32'(err_flag), 32'd1);
    stuck_mw = 1'b0;
    clear_trk();
    samp_busy_len = 2;
    cif.core_out  = 16'h0111;
    sample_data   = 16'h0301;
    sample_valid  = 1'b1;
    run(20);
    check_val("wdog_next_rv", rv_data, 32'h0111);
    check_val("wdog_err_cleared", 32'(err_flag), 32'd0);
`else
    check_val("stuck_err_clear", 32'(err_flag), 32'd0);
    stuck_mw = 1'b0;
    run(10);
    check_val("stuck_release_rv_count", 32'(rv_cnt), 32'd1);
    check_val("stuck_release_rv_data", rv_data, 32'h0BAD);
`endif
    $display("txn stuck_modwait: rv=%0d err_flag=%0b", rv_cnt, err_flag);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
